// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter driving the select of a shared 4:1 datapath mux.
// Optional burst limit: define ARB_BURST_LIMIT_EN to force release after MAX_BURST beats.
module rr_mux_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] req,
    input  logic [3:0] last,
    input  logic       out_ready,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       out_valid,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic       win_found;
    logic [1:0] win_idx;
    logic       beat;
    logic       release_now;

    if (MAX_BURST < 1 || MAX_BURST > 255 || (64'(1) << CNT_W) <= 64'(MAX_BURST)) begin : g_bad_cfg
        $error("rr_mux_arbiter: MAX_BURST must be 1..255 and fit in CNT_W bits");
    end

    // Round-robin search starting just after the last winner; k=4 wraps back
    // to ptr itself so a lone releasing requester can win again.
    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        for (int k = 1; k <= 4; k++) begin
            if (!win_found && req[ptr + 2'(k)]) begin
                win_found = 1'b1;
                win_idx   = ptr + 2'(k);
            end
        end
    end

    assign busy      = (state == BUSY);
    assign out_valid = busy && req[sel];
    assign beat      = out_valid && out_ready;

`ifdef ARB_BURST_LIMIT_EN
    logic [CNT_W-1:0] count;
    logic             limit_hit;

    assign limit_hit   = beat && (count == CNT_W'(MAX_BURST - 1));
    assign release_now = busy && (!req[sel] || (beat && (last[sel] || limit_hit)));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (release_now || state == IDLE) begin
            count <= '0;
        end else if (beat) begin
            count <= count + 1'b1;
        end
    end
`else
    assign release_now = busy && (!req[sel] || (beat && last[sel]));
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            ptr   <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state <= BUSY;
                        gnt   <= 4'b0001 << win_idx;
                        sel   <= win_idx;
                        ptr   <= win_idx;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        if (win_found) begin
                            gnt <= 4'b0001 << win_idx;
                            sel <= win_idx;
                            ptr <= win_idx;
                        end else begin
                            state <= IDLE;
                            gnt   <= 4'b0000;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!resetn) $onehot0(gnt));
    a_sel_matches : assert property (@(posedge clk) disable iff (!resetn) busy |-> gnt[sel]);
    a_idle_no_gnt : assert property (@(posedge clk) disable iff (!resetn) !busy |-> gnt == 4'b0000);
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus random traffic
// compared against a behavioural owner/last-winner model.
module tb_rr_mux_arbiter;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] last = 4'b0000;
    logic       out_ready = 1'b0;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       out_valid;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who owns the mux (-1 = nobody), who won last, beats so far.
    int         owner = -1;
    int         lastw = 3;
    int         beats = 0;
    logic [1:0] m_sel = 2'd0;

    rr_mux_arbiter #(.MAX_BURST(MAXB), .CNT_W(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .last      (last),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt       (gnt),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_outs();
        logic [3:0] g;
        logic       b;
        logic       v;
        g = (owner < 0) ? 4'b0000 : 4'(1 << owner);
        b = (owner >= 0);
        v = (owner >= 0) && req[owner];
        return {g, m_sel, b, v};
    endfunction

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic rd, input logic rn);
        req = r;
        last = l;
        out_ready = rd;
        resetn = rn;
    endtask

    // Work out what the next clock edge must do, then take the edge.
    task automatic advance();
        bit free;
        if (!resetn) begin
            owner = -1;
            lastw = 3;
            beats = 0;
            m_sel = 2'd0;
        end else begin
            free = 1'b1;
            if (owner >= 0) begin
                if (!req[owner]) begin
                    free = 1'b1;
                end else if (out_ready) begin
                    beats = beats + 1;
                    free = last[owner];
`ifdef ARB_BURST_LIMIT_EN
                    if (beats == MAXB) free = 1'b1;
`endif
                end else begin
                    free = 1'b0;
                end
            end
            if (free) begin
                owner = -1;
                for (int k = 1; k <= 4; k++) begin
                    if (req[(lastw + k) % 4]) begin
                        owner = (lastw + k) % 4;
                        break;
                    end
                end
                if (owner >= 0) begin
                    lastw = owner;
                    beats = 0;
                    m_sel = 2'(owner);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 4'b1111, 1'b1, 1'b0);
            advance();
            vectors++;
            if ({gnt, sel, busy, out_valid} !== 8'b0000_00_0_0) begin
                miscompares++;
                $display("FAIL reset: gnt=%b sel=%0d busy=%b ov=%b, want all zero", gnt, sel, busy, out_valid);
            end
        end
    endtask

    task automatic test_single_burst();
        logic [3:0] l_seq [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        logic [3:0] r_seq [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        drive(4'b0000, 4'b0000, 1'b1, 1'b0);
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(r_seq[i], l_seq[i], 1'b1, 1'b1);
            advance();
            vectors++;
            if ({gnt, sel, busy, out_valid} !== exp_outs()) begin
                miscompares++;
                $display("FAIL single_burst[%0d]: gnt=%b sel=%0d busy=%b ov=%b, want %b", i, gnt, sel, busy, out_valid, exp_outs());
            end
        end
        vectors++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_burst_idle: gnt=%b busy=%b, want 0000/0", gnt, busy);
        end
    endtask

    task automatic test_round_robin();
        drive(4'b0000, 4'b0000, 1'b1, 1'b0);
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 4'b1111, 1'b1, 1'b1);
            advance();
            vectors++;
            if (gnt !== 4'(1 << (i % 4)) || sel !== 2'(i % 4) || {gnt, sel, busy, out_valid} !== exp_outs()) begin
                miscompares++;
                $display("FAIL round_robin[%0d]: gnt=%b sel=%0d, want gnt=%b sel=%0d", i, gnt, sel, 4'(1 << (i % 4)), i % 4);
            end
        end
    endtask

    task automatic test_stall();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        advance();
        drive(4'b0100, 4'b0000, 1'b0, 1'b1);
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(4'b1100, 4'b0100, 1'b0, 1'b1);
            advance();
            vectors++;
            if (gnt !== 4'b0100 || out_valid !== 1'b1 || {gnt, sel, busy, out_valid} !== exp_outs()) begin
                miscompares++;
                $display("FAIL stall[%0d]: gnt=%b ov=%b, want 0100/1", i, gnt, out_valid);
            end
        end
        drive(4'b1100, 4'b0100, 1'b1, 1'b1);
        advance();
        vectors++;
        if (gnt !== 4'b1000 || sel !== 2'd3 || {gnt, sel, busy, out_valid} !== exp_outs()) begin
            miscompares++;
            $display("FAIL stall_release: gnt=%b sel=%0d, want 1000/3", gnt, sel);
        end
    endtask

    task automatic test_abort();
        drive(4'b0000, 4'b0000, 1'b1, 1'b0);
        advance();
        drive(4'b0010, 4'b0000, 1'b1, 1'b1);
        advance();
        drive(4'b0011, 4'b0000, 1'b1, 1'b1);
        advance();
        vectors++;
        if (gnt !== 4'b0010 || {gnt, sel, busy, out_valid} !== exp_outs()) begin
            miscompares++;
            $display("FAIL abort_hold: gnt=%b, want 0010", gnt);
        end
        drive(4'b0001, 4'b0000, 1'b1, 1'b1);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_beat: ov=%b, want 0", out_valid);
        end
        advance();
        vectors++;
        if (gnt !== 4'b0001 || sel !== 2'd0 || {gnt, sel, busy, out_valid} !== exp_outs()) begin
            miscompares++;
            $display("FAIL abort_regrant: gnt=%b sel=%0d, want 0001/0", gnt, sel);
        end
    endtask

    task automatic test_reset_mid_burst();
        drive(4'b0000, 4'b0000, 1'b1, 1'b0);
        advance();
        drive(4'b0100, 4'b0000, 1'b1, 1'b1);
        advance();
        drive(4'b0100, 4'b0000, 1'b1, 1'b1);
        advance();
        drive(4'b0100, 4'b0000, 1'b1, 1'b0);
        advance();
        vectors++;
        if ({gnt, busy, out_valid} !== 6'b0000_0_0) begin
            miscompares++;
            $display("FAIL reset_mid_burst: gnt=%b busy=%b ov=%b, want 0000/0/0", gnt, busy, out_valid);
        end
        drive(4'b1111, 4'b0000, 1'b1, 1'b1);
        advance();
        vectors++;
        if (gnt !== 4'b0001 || {gnt, sel, busy, out_valid} !== exp_outs()) begin
            miscompares++;
            $display("FAIL reset_rearb: gnt=%b, want 0001", gnt);
        end
    endtask

`ifdef ARB_BURST_LIMIT_EN
    task automatic test_burst_limit();
        drive(4'b0000, 4'b0000, 1'b1, 1'b0);
        advance();
        for (int i = 0; i < 2 * MAXB + 3; i++) begin
            drive(4'b0011, 4'b0000, 1'b1, 1'b1);
            advance();
            vectors++;
            if ({gnt, sel, busy, out_valid} !== exp_outs()) begin
                miscompares++;
                $display("FAIL burst_limit[%0d]: gnt=%b sel=%0d, want %b", i, gnt, sel, exp_outs());
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] l;
        for (int i = 0; i < 400; i++) begin
            r = 4'($urandom_range(0, 15));
            l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            drive(r, l, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) != 0));
            advance();
            vectors++;
            if ({gnt, sel, busy, out_valid} !== exp_outs()) begin
                miscompares++;
                $display("FAIL random[%0d]: gnt=%b sel=%0d busy=%b ov=%b, want %b", i, gnt, sel, busy, out_valid, exp_outs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_stall();
        test_abort();
        test_reset_mid_burst();
`ifdef ARB_BURST_LIMIT_EN
        test_burst_limit();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Four-requester round-robin arbiter that owns the select of the shared 4:1, 32-bit datapath mux.
- Grants one requester at a time for a burst of beats and drives the 2-bit mux select plus a one-hot grant.
- Qualifies beats with a valid/ready handshake toward the single downstream consumer.
- Sits between the four pipeline/bus masters and the shared result path feeding the downstream stage.

Parameters:
- MAX_BURST, 8, maximum beats per grant before forced release (used only when ARB_BURST_LIMIT_EN is defined); legal range 1..255.
- CNT_W, 8, width of the beat counter; must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk  input  1  system clock, rising-edge.
- resetn  input  1  synchronous, active-low reset.
- req  input  4  per-requester request; the requester holds it high for the whole burst.
- last  input  4  per-requester last-beat flag; sampled only for the granted index.
- out_ready  input  1  downstream accepts the current beat.
- sel  output  2  mux select (index of the granted requester), registered.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- out_valid  output  1  beat valid toward downstream (combinational from state and req).
- busy  output  1  high while a grant is held.

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE, gnt=4'b0000, sel=2'd0, busy=0, out_valid=0, beat count=0, rr pointer=3 (requester 0 wins the first arbitration). Reset mid-burst drops the grant at that edge with no further beats.
- States: IDLE and BUSY. busy = (state==BUSY).
- Arbitration order starts at ptr+1 mod 4 and searches upward with wrap-around; the first index with req high wins.
- IDLE: if any req is high, the winner is registered at the next edge (gnt, sel, state=BUSY, ptr=winner, count=0). Latency is one cycle from req to gnt. With no requests, the block stays IDLE.
- BUSY: out_valid = req[sel]. Beat = out_valid && out_ready. Each beat increments count.
- Release conditions in BUSY, evaluated each cycle:
  - (a) beat with last[sel]=1.
  - (b) req[sel]=0, an abort: no beat, and the burst is abandoned.
  - (c) burst limit reached, only with ARB_BURST_LIMIT_EN.
- On release, re-arbitrate in the same cycle, searching from ptr+1:
  - If another request is pending, including the releasing requester when it is the only one, the new grant is loaded at the next edge with no idle bubble and count=0.
  - Otherwise the block goes to IDLE with gnt=0 and sel held at its last value.
- Requests from non-granted requesters never preempt an active grant.
- last and req of non-granted indices are ignored.
- out_ready=0 stalls the burst indefinitely. Grant, sel and count hold, and no timeout applies to stalls.
- gnt is always one-hot or zero, and sel always equals the index of the gnt bit while busy.

Optional Feature:
- Macro ARB_BURST_LIMIT_EN.
- Defined: a beat that brings count to MAX_BURST forces release exactly as a last beat does, even if last[sel]=0. The requester must re-win arbitration to continue.
- Undefined: the beat counter and the limit are not built, and a grant is held until a last beat or an abort. Every other behaviour is identical.

Test Plan:
- Reset then req=4'b0001, last[0] high on beat 3, out_ready=1 -> gnt=0001 one cycle after req, sel=0, three beats, then IDLE with gnt=0000.
- req=4'b1111, each burst one beat with last=1, out_ready=1 -> grant sequence 0,1,2,3,0 on consecutive cycles, with no bubble between grants.
- Requester 2 granted; req[3] asserts mid-burst; out_ready held 0 for 5 cycles -> gnt stays 0100, out_valid stays 1 and no beat is counted; gnt moves to 1000 on the cycle after req[2]'s last beat is accepted.
- Requester 1 granted; req[1] drops with no last while req[0] is high -> the next edge gives gnt=0001 and no beat is produced in the drop cycle.
- ARB_BURST_LIMIT_EN with MAX_BURST=4; req=0011, last never set, out_ready=1 -> requester 0 gets 4 beats, then requester 1 gets 4 beats, then requester 0 again.
- Reset asserted during a BUSY burst -> after that edge gnt=0000, busy=0, out_valid=0; the next arbitration picks requester 0 first.
